// File: rtl/jdeb_pkg.sv
// Shared definitions for the j debounce path: Gray-ordered FSM encoding and
// the chatter counter ceiling.
package jdeb_pkg;

  localparam logic [1:0] ST_LO     = 2'b00;
  localparam logic [1:0] ST_CHK_HI = 2'b01;
  localparam logic [1:0] ST_HI     = 2'b11;
  localparam logic [1:0] ST_CHK_LO = 2'b10;

  localparam logic [7:0] CHATTER_MAX = 8'hFF;

  typedef enum logic [1:0] {
    S_LO     = ST_LO,
    S_CHK_HI = ST_CHK_HI,
    S_HI     = ST_HI,
    S_CHK_LO = ST_CHK_LO
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// N-stage level synchronizer; all stages clear to 0 on reset.
module sync_ff #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb sync_d = {sync_q[N-2:0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/j_debounce.sv
// Synchronizes a raw level and only passes a transition once the new level has
// held for DEBOUNCE_CYCLES cycles; drives registered j, edge strobes and a chatter count.
module j_debounce
  import jdeb_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_in,
  input  logic       en,
  input  logic       chatter_clr,
  output logic       j,
  output logic       j_rise,
  output logic       j_fall,
  output logic [7:0] chatter_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             j_q, j_d;
  logic             j_rise_q, j_rise_d;
  logic             j_fall_q, j_fall_d;
  logic [7:0]       chatter_q, chatter_d;
  logic             abort;

  sync_ff #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (raw_in),
    .q     (s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    unique case (state_q)
      S_LO: if (en && s) begin
        state_d = S_CHK_HI;
        cnt_d   = '0;
      end
      S_CHK_HI: begin
        if (!en) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_LO;
          cnt_d   = '0;
          abort   = 1'b1;
        end
      end
      S_HI: if (en && !s) begin
        state_d = S_CHK_LO;
        cnt_d   = '0;
      end
      S_CHK_LO: begin
        if (!en) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (!s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = S_HI;
          cnt_d   = '0;
          abort   = 1'b1;
        end
      end
      default: begin
        state_d = S_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // j follows the decided state, so it moves on the same edge the FSM accepts.
  always_comb begin
    j_d      = (state_d == S_HI) || (state_d == S_CHK_LO);
    j_rise_d = j_d & ~j_q;
    j_fall_d = ~j_d & j_q;
    if (chatter_clr)                          chatter_d = '0;
    else if (abort && chatter_q != CHATTER_MAX) chatter_d = chatter_q + 8'd1;
    else                                      chatter_d = chatter_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LO;
      cnt_q     <= '0;
      j_q       <= 1'b0;
      j_rise_q  <= 1'b0;
      j_fall_q  <= 1'b0;
      chatter_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      j_rise_q  <= j_rise_d;
      j_fall_q  <= j_fall_d;
      chatter_q <= chatter_d;
    end
  end

  assign j           = j_q;
  assign j_rise      = j_rise_q;
  assign j_fall      = j_fall_q;
  assign chatter_cnt = chatter_q;

endmodule
